// File: rtl/perf_monitor_if.sv
// perf_monitor_if
//   Bundles the run-statistics monitor's stimulus inputs and statistic
//   outputs. The slave modport is used by perf_monitor. The master modport is
//   for whatever drives the monitor and reads the counts.
//
//   halt       halt instruction observed at writeback
//   retire_v   per-lane retire valid
//   evt        per-channel event pulse
//   freeze     pause counting (debug stall)
//   cycle      cycles counted
//   instrs     instructions retired (saturating)
//   evt_count  event counters, channel i at [i*EVT_W +: EVT_W] (saturating)
//   evt_ovf    sticky per-channel saturation flag
//   running    high while RUN or DRAIN
//   done       high in DONE
//   timeout    sticky, DONE reached through the cycle budget
//   finish     one-cycle pulse on entry to DONE
interface perf_monitor_if #(
    parameter int CYCLE_W  = 32,
    parameter int INS_W    = 32,
    parameter int RETIRE_W = 2,
    parameter int NUM_EVT  = 4,
    parameter int EVT_W    = 24
);
    logic                       halt;
    logic [RETIRE_W-1:0]        retire_v;
    logic [NUM_EVT-1:0]         evt;
    logic                       freeze;
    logic [CYCLE_W-1:0]         cycle;
    logic [INS_W-1:0]           instrs;
    logic [NUM_EVT*EVT_W-1:0]   evt_count;
    logic [NUM_EVT-1:0]         evt_ovf;
    logic                       running;
    logic                       done;
    logic                       timeout;
    logic                       finish;

    modport master (
        output halt, retire_v, evt, freeze,
        input  cycle, instrs, evt_count, evt_ovf, running, done, timeout, finish
    );

    modport slave (
        input  halt, retire_v, evt, freeze,
        output cycle, instrs, evt_count, evt_ovf, running, done, timeout, finish
    );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor
//   Counts cycles, retired instructions and auxiliary events. It stops on
//   halt, after a drain window, or when the cycle budget runs out. It then
//   freezes every statistic and pulses finish once.
//
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   mon    perf_monitor_if.slave (inputs halt/retire_v/evt/freeze, all
//          statistics and status outputs, every output registered)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | counting; accepts halt; checks the cycle budget
//   ST_DRAIN | counting; drain_q counts down the cycles left before DONE
//   ST_DONE  | terminal until reset; all statistics hold
module perf_monitor #(
    parameter int CYCLE_W      = 32,
    parameter int INS_W        = 32,
    parameter int RETIRE_W     = 2,
    parameter int NUM_EVT      = 4,
    parameter int EVT_W        = 24,
    parameter int MAX_CYCLES   = 100000,
    parameter int DRAIN_CYCLES = 4
) (
    input logic           clk,
    input logic           reset,
    perf_monitor_if.slave mon
);
    localparam int RC_W  = $clog2(RETIRE_W + 1);
    localparam int DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int SUM_W = INS_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [CYCLE_W-1:0]       cycle_q, cycle_d;
    logic [INS_W-1:0]         instrs_q, instrs_d;
    logic [NUM_EVT*EVT_W-1:0] evt_count_q, evt_count_d;
    logic [NUM_EVT-1:0]       evt_ovf_q, evt_ovf_d;
    logic [DRN_W-1:0]         drain_q;
    logic                     running_q, done_q, timeout_q, finish_q;

    logic                     active;
    logic [RC_W-1:0]          retire_cnt;
    logic [SUM_W-1:0]         instr_sum;

    always_comb begin
        // DRAIN with a zero count only exists when DRAIN_CYCLES=0. That cycle
        // is a pure hand-off to DONE and is not counted.
        active = !mon.freeze &&
                 ((state_q == ST_RUN) || (state_q == ST_DRAIN && drain_q != '0));

        retire_cnt = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            retire_cnt = retire_cnt + RC_W'(mon.retire_v[i]);
        end
        instr_sum = {1'b0, instrs_q} + SUM_W'(retire_cnt);

        cycle_d     = cycle_q;
        instrs_d    = instrs_q;
        evt_count_d = evt_count_q;
        evt_ovf_d   = evt_ovf_q;
        if (active) begin
            cycle_d  = cycle_q + CYCLE_W'(1);
            instrs_d = instr_sum[INS_W] ? '1 : instr_sum[INS_W-1:0];
            for (int i = 0; i < NUM_EVT; i++) begin
                if (mon.evt[i]) begin
                    if (&evt_count_q[i*EVT_W +: EVT_W]) begin
                        evt_ovf_d[i] = 1'b1;
                    end else begin
                        evt_count_d[i*EVT_W +: EVT_W] =
                            evt_count_q[i*EVT_W +: EVT_W] + EVT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cycle_q     <= '0;
            instrs_q    <= '0;
            evt_count_q <= '0;
            evt_ovf_q   <= '0;
            drain_q     <= '0;
            running_q   <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            instrs_q    <= instrs_d;
            evt_count_q <= evt_count_d;
            evt_ovf_q   <= evt_ovf_d;
            finish_q    <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // halt is accepted even while frozen and beats a
                    // simultaneous budget expiry.
                    if (mon.halt) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DRN_W'(DRAIN_CYCLES);
                    end else if (active && cycle_q == CYCLE_W'(MAX_CYCLES - 1)) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        finish_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0 || (active && drain_q == DRN_W'(1))) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        finish_q  <= 1'b1;
                    end else if (active) begin
                        drain_q <= drain_q - DRN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mon.cycle     = cycle_q;
    assign mon.instrs    = instrs_q;
    assign mon.evt_count = evt_count_q;
    assign mon.evt_ovf   = evt_ovf_q;
    assign mon.running   = running_q;
    assign mon.done      = done_q;
    assign mon.timeout   = timeout_q;
    assign mon.finish    = finish_q;
endmodule

// File: tb/tb_perf_monitor.sv
// Testbench for perf_monitor. Two instances share one stimulus: dut uses
// DRAIN_CYCLES=4 and dut0 uses DRAIN_CYCLES=0. Both use MAX_CYCLES=100 and
// EVT_W=4. Stimulus is driven on the falling edge. Expected snapshots and
// expected finish records are queued by the stimulus process. Monitors
// sample 1 time unit after each rising edge, pop the queues and compare.
module tb_perf_monitor;
    localparam int CYCLE_W  = 32;
    localparam int INS_W    = 32;
    localparam int RETIRE_W = 2;
    localparam int NUM_EVT  = 4;
    localparam int EVT_W    = 4;
    localparam int MAX_C    = 100;

    typedef struct {
        string       tag;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [15:0] evtc;
        logic [3:0]  ovf;
        logic        run;
        logic        dn;
        logic        to;
        logic        fin;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic snap_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exp_t snap_q[$];
    exp_t fin_q[$];
    exp_t fin0_q[$];

    always #5 clk = ~clk;

    perf_monitor_if #(.CYCLE_W(CYCLE_W), .INS_W(INS_W), .RETIRE_W(RETIRE_W),
                      .NUM_EVT(NUM_EVT), .EVT_W(EVT_W)) ifc ();
    perf_monitor_if #(.CYCLE_W(CYCLE_W), .INS_W(INS_W), .RETIRE_W(RETIRE_W),
                      .NUM_EVT(NUM_EVT), .EVT_W(EVT_W)) ifc0 ();

    assign ifc0.halt     = ifc.halt;
    assign ifc0.retire_v = ifc.retire_v;
    assign ifc0.evt      = ifc.evt;
    assign ifc0.freeze   = ifc.freeze;

    perf_monitor #(.CYCLE_W(CYCLE_W), .INS_W(INS_W), .RETIRE_W(RETIRE_W),
                   .NUM_EVT(NUM_EVT), .EVT_W(EVT_W), .MAX_CYCLES(MAX_C),
                   .DRAIN_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (ifc.slave)
    );

    perf_monitor #(.CYCLE_W(CYCLE_W), .INS_W(INS_W), .RETIRE_W(RETIRE_W),
                   .NUM_EVT(NUM_EVT), .EVT_W(EVT_W), .MAX_CYCLES(MAX_C),
                   .DRAIN_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .mon   (ifc0.slave)
    );

    function automatic exp_t mk(input string tag, input int cyc, input int ins,
                                input logic [15:0] evtc, input logic [3:0] ovf,
                                input logic run, input logic dn, input logic to,
                                input logic fin);
        exp_t e;
        e.tag = tag; e.cyc = cyc; e.ins = ins; e.evtc = evtc; e.ovf = ovf;
        e.run = run; e.dn = dn; e.to = to; e.fin = fin;
        return e;
    endfunction

    task automatic chk(input string tag, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", tag, f, act, exp);
        end
    endtask

    task automatic cmp_all(input string who, input exp_t e, input exp_t a);
        string t;
        t = {who, ":", e.tag};
        chk(t, "cycle",     a.cyc,          e.cyc);
        chk(t, "instrs",    a.ins,          e.ins);
        chk(t, "evt_count", 32'(a.evtc),    32'(e.evtc));
        chk(t, "evt_ovf",   32'(a.ovf),     32'(e.ovf));
        chk(t, "running",   32'(a.run),     32'(e.run));
        chk(t, "done",      32'(a.dn),      32'(e.dn));
        chk(t, "timeout",   32'(a.to),      32'(e.to));
        chk(t, "finish",    32'(a.fin),     32'(e.fin));
    endtask

    // Queue the state expected right after the next rising edge, then let
    // that edge happen.
    task automatic expect_next(input exp_t e);
        snap_q.push_back(e);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    // Reset for one edge with whatever inputs are currently driven, which
    // the block must discard. Then clear the inputs.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        expect_next(mk(tag, 0, 0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        ifc.halt = 1'b0; ifc.retire_v = '0; ifc.evt = '0; ifc.freeze = 1'b0;
    endtask

    // Monitor for dut: snapshots on request, finish records whenever finish is high.
    initial begin
        exp_t a, e;
        logic prev_fin;
        prev_fin = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            a = mk("act", 0, 0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            a.cyc = ifc.cycle; a.ins = ifc.instrs; a.evtc = ifc.evt_count;
            a.ovf = ifc.evt_ovf; a.run = ifc.running; a.dn = ifc.done;
            a.to = ifc.timeout; a.fin = ifc.finish;
            if (snap_req) begin
                if (snap_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL snap_queue actual=empty expected=entry");
                end else begin
                    e = snap_q.pop_front();
                    cmp_all("dut", e, a);
                end
            end
            if (a.fin) begin
                chk("dut", "finish_width", 32'(prev_fin), 32'd0);
                if (fin_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut.unexpected_finish actual=1 expected=0 cycle=%0d", a.cyc);
                end else begin
                    e = fin_q.pop_front();
                    cmp_all("dut", e, a);
                end
            end
            prev_fin = a.fin;
        end
    end

    // Monitor for dut0 (DRAIN_CYCLES=0): finish records only.
    initial begin
        exp_t a, e;
        logic prev_fin;
        prev_fin = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            a = mk("act", 0, 0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            a.cyc = ifc0.cycle; a.ins = ifc0.instrs; a.evtc = ifc0.evt_count;
            a.ovf = ifc0.evt_ovf; a.run = ifc0.running; a.dn = ifc0.done;
            a.to = ifc0.timeout; a.fin = ifc0.finish;
            if (a.fin) begin
                chk("dut0", "finish_width", 32'(prev_fin), 32'd0);
                if (fin0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0.unexpected_finish actual=1 expected=0 cycle=%0d", a.cyc);
                end else begin
                    e = fin0_q.pop_front();
                    cmp_all("dut0", e, a);
                end
            end
            prev_fin = a.fin;
        end
    end

    initial begin
        ifc.halt = 1'b0; ifc.retire_v = '0; ifc.evt = '0; ifc.freeze = 1'b0;
        repeat (2) @(negedge clk);

        // Idle counting with both lanes retiring
        do_reset("t1_reset");
        ifc.retire_v = 2'b11;
        repeat (9) @(negedge clk);
        expect_next(mk("t1_idle", 10, 20, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));

        // halt accepted on the edge that makes cycle=50, then a 4-cycle drain
        do_reset("t2_reset");
        ifc.retire_v = 2'b01;
        repeat (49) @(negedge clk);
        ifc.halt = 1'b1;
        fin_q.push_back(mk("t2_fin", 54, 54, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        fin0_q.push_back(mk("t2_fin0", 50, 50, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        expect_next(mk("t2_halt", 50, 50, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        ifc.halt = 1'b0;
        repeat (2) @(negedge clk);
        expect_next(mk("t2_drain", 53, 53, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (5) @(negedge clk);
        expect_next(mk("t2_hold", 54, 54, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Cycle budget timeout (reset issued while in DONE)
        do_reset("t3_reset");
        ifc.retire_v = 2'b11;
        repeat (98) @(negedge clk);
        expect_next(mk("t3_pre", 99, 198, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        fin_q.push_back(mk("t3_fin", 100, 200, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        fin0_q.push_back(mk("t3_fin0", 100, 200, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        repeat (4) @(negedge clk);
        expect_next(mk("t3_hold", 100, 200, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0));

        // halt in the same cycle the budget would expire: halt wins
        do_reset("t4_reset");
        ifc.retire_v = 2'b01;
        repeat (99) @(negedge clk);
        ifc.halt = 1'b1;
        fin_q.push_back(mk("t4_fin", 104, 104, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        fin0_q.push_back(mk("t4_fin0", 100, 100, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        expect_next(mk("t4_halt", 100, 100, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        ifc.halt = 1'b0;
        repeat (6) @(negedge clk);
        expect_next(mk("t4_hold", 104, 104, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Event counter saturation and sticky overflow on channel 2
        do_reset("t5_reset");
        ifc.evt = 4'b0100;
        repeat (14) @(negedge clk);
        expect_next(mk("t5_sat", 15, 0, 16'h0F00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        expect_next(mk("t5_ovf", 20, 0, 16'h0F00, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0));
        ifc.evt = 4'b1001;
        repeat (2) @(negedge clk);
        expect_next(mk("t5_mix", 23, 0, 16'h3F03, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0));

        // freeze in RUN, halt while frozen, stretched DRAIN, reset in DONE
        do_reset("t6_reset_midrun");
        ifc.retire_v = 2'b11;
        repeat (10) @(negedge clk);
        ifc.freeze = 1'b1;
        repeat (4) @(negedge clk);
        expect_next(mk("t6_frz", 10, 20, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        ifc.freeze = 1'b0;
        repeat (4) @(negedge clk);
        expect_next(mk("t6_unfrz", 15, 30, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        ifc.freeze = 1'b1;
        ifc.halt = 1'b1;
        fin_q.push_back(mk("t6_fin", 19, 38, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        fin0_q.push_back(mk("t6_fin0", 15, 30, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        expect_next(mk("t6_frzhalt", 15, 30, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        ifc.halt = 1'b0;
        repeat (2) @(negedge clk);
        expect_next(mk("t6_drainfrz", 15, 30, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        ifc.freeze = 1'b0;
        repeat (5) @(negedge clk);
        expect_next(mk("t6_done", 19, 38, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        ifc.evt = 4'b1111;
        ifc.halt = 1'b1;
        do_reset("t6_reset_done");
        repeat (2) @(negedge clk);

        checks++;
        if (snap_q.size() != 0) begin
            errors++;
            $display("FAIL snap_leftover actual=%0d expected=0", snap_q.size());
        end
        checks++;
        if (fin_q.size() != 0) begin
            errors++;
            $display("FAIL dut.missing_finish actual=%0d expected=0", fin_q.size());
        end
        checks++;
        if (fin0_q.size() != 0) begin
            errors++;
            $display("FAIL dut0.missing_finish actual=%0d expected=0", fin0_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
